// File: rtl/bitcoin_host_ctrl.sv
// Host-bus loader and mining controller driving one external hash core.
// Loads a header, hashes once or searches nonces, streams result back.
module bitcoin_host_ctrl #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 8,
  parameter int BLOCK_W   = 640,
  parameter int HASH_W    = 256,
  parameter int NONCE_W   = 32,
  parameter int NONCE_LSB = 0,
  parameter int ZW        = 9,
  parameter int ADDR_W    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [ZW-1:0]      target_zeros,
  input  logic [IN_W-1:0]    data_in,
  input  logic               ack,
  input  logic               restart,
  output logic [ADDR_W-1:0]  addr,
  output logic [OUT_W-1:0]   data_out,
  output logic               data_oe,
  output logic               rq,
  output logic               done,
  output logic               found,
  output logic               core_start,
  output logic [BLOCK_W-1:0] core_block,
  input  logic [HASH_W-1:0]  core_hash,
  input  logic               core_done
);

  localparam int NW = BLOCK_W / IN_W;
  localparam int NH = HASH_W / OUT_W;
  localparam int NN = NONCE_W / OUT_W;
  localparam int RW = HASH_W + NONCE_W;

  typedef enum logic [2:0] {
    LOAD, HASH_START, HASH_WAIT, CHECK, WRITE, IDLE
  } state_t;

  state_t state, state_d;

  logic [ADDR_W-1:0]  addr_d;
  logic [OUT_W-1:0]   data_out_d;
  logic               data_oe_d, rq_d, done_d, found_d;
  logic [BLOCK_W-1:0] core_block_d;
  logic [HASH_W-1:0]  hash_r, hash_d;
  logic               mode_r, mode_d;
  logic [ZW-1:0]      tz_r, tz_d;
  logic [NONCE_W-1:0] start_nonce, start_d;
  logic               ack_q;

  logic               ack_rise;
  logic [NONCE_W-1:0] nonce, nonce_nxt;
  logic [HASH_W-1:0]  mask;
  logic               hit;
  logic [RW-1:0]      result;
  logic [ADDR_W-1:0]  n_words, addr_inc;

  assign ack_rise  = ack & ~ack_q;
  assign nonce     = core_block[NONCE_LSB +: NONCE_W];
  assign nonce_nxt = nonce + NONCE_W'(1);
  // Shifting by >= HASH_W clears everything, so the mask covers all bits
  assign mask      = ~({HASH_W{1'b1}} >> tz_r);
  assign hit       = (hash_r & mask) == '0;
  assign result    = {hash_r, nonce};
  assign n_words   = mode_r ? ADDR_W'(NH + NN) : ADDR_W'(NH);
  assign addr_inc  = addr + ADDR_W'(1);

  always_comb begin
    state_d      = state;
    addr_d       = addr;
    data_oe_d    = data_oe;
    rq_d         = rq;
    done_d       = 1'b0;
    found_d      = found;
    core_block_d = core_block;
    hash_d       = hash_r;
    mode_d       = mode_r;
    tz_d         = tz_r;
    start_d      = start_nonce;
    unique case (state)
      LOAD: begin
        rq_d = 1'b1;
        // rq gating keeps an ack already high at reset exit from loading
        if (rq && ack_rise) begin
          for (int i = 0; i < NW; i++)
            if (addr == ADDR_W'(i))
              core_block_d[BLOCK_W-1-i*IN_W -: IN_W] = data_in;
          if (addr == ADDR_W'(NW - 1)) begin
            addr_d  = '0;
            rq_d    = 1'b0;
            mode_d  = mode;
            tz_d    = target_zeros;
            start_d = core_block_d[NONCE_LSB +: NONCE_W];
            state_d = HASH_START;
          end else begin
            addr_d = addr_inc;
          end
        end
      end
      HASH_START: state_d = HASH_WAIT;
      HASH_WAIT: begin
        if (core_done) begin
          hash_d  = core_hash;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!mode_r || hit || nonce_nxt == start_nonce) begin
          found_d   = !mode_r || hit;
          done_d    = 1'b1;
          data_oe_d = 1'b1;
          rq_d      = 1'b1;
          addr_d    = '0;
          state_d   = WRITE;
        end else begin
          core_block_d[NONCE_LSB +: NONCE_W] = nonce_nxt;
          state_d = HASH_START;
        end
      end
      WRITE: begin
        if (rq && ack_rise) begin
          addr_d = addr_inc;
          if (addr_inc == n_words) begin
            rq_d      = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      IDLE: begin
        done_d = 1'b1;
        if (restart) begin
          addr_d  = '0;
          done_d  = 1'b0;
          found_d = 1'b0;
          rq_d    = 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase

    data_out_d = data_out;
    if (state_d == WRITE)
      for (int k = 0; k < NH + NN; k++)
        if (addr_d == ADDR_W'(k))
          data_out_d = result[RW-1-k*OUT_W -: OUT_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= LOAD;
      addr        <= '0;
      data_out    <= '0;
      data_oe     <= 1'b0;
      rq          <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      core_start  <= 1'b0;
      core_block  <= '0;
      hash_r      <= '0;
      mode_r      <= 1'b0;
      tz_r        <= '0;
      start_nonce <= '0;
      ack_q       <= 1'b0;
    end else begin
      state       <= state_d;
      addr        <= addr_d;
      data_out    <= data_out_d;
      data_oe     <= data_oe_d;
      rq          <= rq_d;
      done        <= done_d;
      found       <= found_d;
      core_start  <= (state_d == HASH_START);
      core_block  <= core_block_d;
      hash_r      <= hash_d;
      mode_r      <= mode_d;
      tz_r        <= tz_d;
      start_nonce <= start_d;
      ack_q       <= ack;
    end
  end

endmodule

// File: tb/tb_bitcoin_host_ctrl.sv
// Scoreboard bench for bitcoin_host_ctrl with mock hash cores.
// Second small instance exercises nonce-space exhaustion.
module tb_bitcoin_host_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, rst2_n, mode, restart, ack;
  logic [8:0]   tz;
  logic [4:0]   tz2;
  logic [15:0]  data_in;

  logic [5:0]   addr;
  logic [7:0]   data_out;
  logic         data_oe, rq, done, found, core_start;
  logic [639:0] core_block;
  logic [255:0] core_hash = '0;
  logic         core_done = 1'b0;

  logic [2:0]   addr2;
  logic [3:0]   data_out2;
  logic         data_oe2, rq2, done2, found2, core_start2;
  logic [31:0]  core_block2;
  logic [15:0]  core_hash2;
  logic         core_done2 = 1'b0;

  assign core_hash2 = 16'h1234;

  bitcoin_host_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .target_zeros(tz),
    .data_in(data_in), .ack(ack), .restart(restart), .addr(addr),
    .data_out(data_out), .data_oe(data_oe), .rq(rq), .done(done),
    .found(found), .core_start(core_start), .core_block(core_block),
    .core_hash(core_hash), .core_done(core_done)
  );

  bitcoin_host_ctrl #(
    .IN_W(16), .OUT_W(4), .BLOCK_W(32), .HASH_W(16), .NONCE_W(4),
    .NONCE_LSB(0), .ZW(5), .ADDR_W(3)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n), .mode(mode), .target_zeros(tz2),
    .data_in(data_in), .ack(ack), .restart(restart), .addr(addr2),
    .data_out(data_out2), .data_oe(data_oe2), .rq(rq2), .done(done2),
    .found(found2), .core_start(core_start2), .core_block(core_block2),
    .core_hash(core_hash2), .core_done(core_done2)
  );

  int checks = 0;
  int failures = 0;
  int sel = 0;

  typedef struct {
    logic [7:0] d;
    int         a;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, expv);
    end
  endtask

  // Mock cores: answer 4 (resp. 3) cycles after a start pulse
  logic         hit_en = 1'b0;
  logic [31:0]  hit_nonce = '0;
  int starts = 0, starts2 = 0, cnt = 0, cnt2 = 0;

  function automatic logic [255:0] mock_hash(input logic [31:0] n);
    if (hit_en && n == hit_nonce) return {8'h00, {31{8'hAB}}};
    return {32{8'hAB}};
  endfunction

  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_start) begin
      starts <= starts + 1;
      cnt    <= 3;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        core_done <= 1'b1;
        core_hash <= mock_hash(core_block[31:0]);
      end
    end
  end

  always @(posedge clk) begin
    core_done2 <= 1'b0;
    if (core_start2) begin
      starts2 <= starts2 + 1;
      cnt2    <= 2;
    end else if (cnt2 != 0) begin
      cnt2 <= cnt2 - 1;
      if (cnt2 == 1) core_done2 <= 1'b1;
    end
  end

  // Monitor: on each host ack edge during a write, pop and compare
  logic ack_p = 1'b0;
  always @(negedge clk) begin
    if (ack && !ack_p &&
        (sel == 0 ? (rq && data_oe) : (rq2 && data_oe2))) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty got=%0h exp=none", data_out);
      end else begin
        e = exp_q.pop_front();
        chk("word", sel == 0 ? 64'(data_out) : 64'(data_out2), 64'(e.d));
        chk("word_addr", sel == 0 ? 64'(addr) : 64'(addr2), 64'(e.a));
      end
    end
    ack_p = ack;
  end

  function automatic bit cond(input int w);
    case (w)
      0: return rq;
      1: return rq2;
      2: return data_oe;
      default: return data_oe2;
    endcase
  endfunction

  task automatic wait_for(input int w, input string nm);
    int n = 0;
    @(negedge clk);
    while (!cond(w) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cond(w)) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s got=0 exp=1", nm);
    end
  endtask

  task automatic load(input int s, input logic [639:0] b,
                      input int nw, input int first);
    for (int i = first; i < nw; i++) begin
      wait_for(s, "rq_load");
      data_in = b[nw*16-1-16*i -: 16];
      @(posedge clk); #1 ack = 1'b1;
      @(posedge clk); #1 ack = 1'b0;
    end
  endtask

  task automatic read(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      wait_for(s, "rq_write");
      @(posedge clk); #1 ack = 1'b1;
      @(posedge clk); #1 ack = 1'b0;
    end
  endtask

  task automatic expect_write(input int s, input logic f);
    wait_for(s + 2, "write");
    chk("done_pulse", 64'(s == 0 ? done : done2), 64'(1));
    chk("found_entry", 64'(s == 0 ? found : found2), 64'(f));
  endtask

  task automatic after_read(input int s, input logic f);
    @(negedge clk);
    chk("idle_rq", 64'(s == 0 ? rq : rq2), 64'(0));
    chk("idle_oe", 64'(s == 0 ? data_oe : data_oe2), 64'(0));
    chk("idle_done", 64'(s == 0 ? done : done2), 64'(1));
    chk("idle_found", 64'(s == 0 ? found : found2), 64'(f));
  endtask

  task automatic push_words(input logic [255:0] h, input logic [31:0] n,
                            input bit with_n);
    for (int k = 0; k < 32; k++) exp_q.push_back('{d: h[255-8*k -: 8], a: k});
    if (with_n)
      for (int j = 0; j < 4; j++)
        exp_q.push_back('{d: n[31-8*j -: 8], a: 32 + j});
  endtask

  task automatic do_restart();
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    @(negedge clk);
    chk("rs_rq", 64'(rq), 64'(1));
    chk("rs_addr", 64'(addr), 64'(0));
    chk("rs_done", 64'(done), 64'(0));
    chk("rs_found", 64'(found), 64'(0));
  endtask

  task automatic rst_vals();
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_dout", 64'(data_out), 64'(0));
    chk("rst_oe", 64'(data_oe), 64'(0));
    chk("rst_rq", 64'(rq), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_found", 64'(found), 64'(0));
    chk("rst_start", 64'(core_start), 64'(0));
    chk("rst_block_zero", 64'(core_block == '0), 64'(1));
  endtask

  task automatic mine(input logic [31:0] n0, input logic [8:0] z,
                      input bit hen, input logic [31:0] hn,
                      input logic [255:0] h, input logic [31:0] nf,
                      input int nstarts);
    logic [639:0] b;
    int s0;
    b = '0;
    b[31:0] = n0;
    mode = 1'b1;
    tz = z;
    hit_en = hen;
    hit_nonce = hn;
    s0 = starts;
    push_words(h, nf, 1'b1);
    load(0, b, 40, 0);
    expect_write(0, 1'b1);
    read(0, 36);
    after_read(0, 1'b1);
    chk("start_count", 64'(starts - s0), 64'(nstarts));
  endtask

  logic [639:0] blk;
  int s0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0; ack = 1'b0; restart = 1'b0;
    mode = 1'b0; tz = '0; tz2 = '0; data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_vals();
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) blk[639-16*i -: 16] = 16'(i);
    push_words({32{8'hAB}}, '0, 1'b0);
    load(0, blk, 40, 0);
    @(negedge clk);
    chk("blk_top", 64'(core_block[639:624]), 64'h0000);
    chk("blk_bot", 64'(core_block[15:0]), 64'h0027);
    expect_write(0, 1'b1);
    read(0, 32);
    after_read(0, 1'b1);
    chk("start_count", 64'(starts), 64'(1));

    do_restart();
    mine(32'h10, 9'd8, 1'b1, 32'h13, {8'h00, {31{8'hAB}}}, 32'h13, 4);
    do_restart();
    mine(32'hFFFF_FFFE, 9'd8, 1'b1, 32'h1, {8'h00, {31{8'hAB}}}, 32'h1, 4);
    do_restart();
    mine(32'h55, 9'd0, 1'b0, '0, {32{8'hAB}}, 32'h55, 1);

    do_restart();
    mode = 1'b0;
    wait_for(0, "rq_hold");
    data_in = 16'hBEEF;
    @(posedge clk); #1 ack = 1'b1;
    repeat (10) @(posedge clk);
    #1 ack = 1'b0;
    @(negedge clk);
    chk("hold_addr", 64'(addr), 64'(1));
    chk("hold_word", 64'(core_block[639:624]), 64'hBEEF);
    blk[639:624] = 16'hBEEF;
    s0 = starts;
    load(0, blk, 40, 1);
    @(posedge clk); #1;
    ack = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    rst_vals();
    repeat (8) @(negedge clk);
    chk("late_addr", 64'(addr), 64'(0));
    chk("late_block_zero", 64'(core_block == '0), 64'(1));
    chk("late_rq", 64'(rq), 64'(1));
    chk("late_done", 64'(done), 64'(0));
    chk("late_starts", 64'(starts - s0), 64'(1));
    ack = 1'b0;

    rst_n = 1'b0;
    sel = 1;
    @(negedge clk);
    rst2_n = 1'b1;
    mode = 1'b1;
    tz2 = 5'd16;
    blk = '0;
    blk[31:0] = 32'hCAFE_0005;
    for (int k = 0; k < 4; k++) exp_q.push_back('{d: 8'(k + 1), a: k});
    exp_q.push_back('{d: 8'h04, a: 4});
    load(1, blk, 2, 0);
    expect_write(1, 1'b0);
    read(1, 5);
    after_read(1, 1'b0);
    chk("exhaust_starts", 64'(starts2), 64'(16));

    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
